// File: rtl/y86_pkg.sv
// y86_pkg: shared icodes, fetch FSM states and instruction length function
package y86_pkg;
  localparam int INSTR_W = 80;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_ERR_IMM, S_DONE} state_t;
  function automatic logic [3:0] ilen(input logic [3:0] icode);
    ilen = (icode inside {I_HALT, I_NOP, I_RET}) ? 4'd1 :
           (icode inside {I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ}) ? 4'd2 :
           (icode inside {I_JXX, I_CALL}) ? 4'd9 :
           (icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) ? 4'd10 : 4'd1;
  endfunction
endpackage

// File: rtl/y86_ilen_decode.sv
// y86_ilen_decode: icode to instruction length in bytes
module y86_ilen_decode
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic [3:0] o_len
);
  assign o_len = ilen(i_icode);
endmodule

// File: rtl/y86_ifetch_server.sv
// y86_ifetch_server: reads an instruction byte-by-byte from sync memory and returns the 80-bit fetch word
module y86_ifetch_server
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ADDR_W-1:0]  i_req_pc,
  output logic               o_mem_rd_en,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [7:0]         i_mem_rd_data,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [INSTR_W-1:0] o_resp_instruct,
  output logic [3:0]         o_resp_len,
  output logic               o_resp_err
);
  localparam int AW1 = ADDR_W + 1;
  state_t r_state, w_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [3:0]         r_i, r_len;
  logic               r_err, r_rd_q;
  logic [INSTR_W-1:0] r_buf;
  logic [AW1-1:0]     w_addr, w_end;
  logic [3:0]         w_k, w_dec_len, w_len;
  logic               w_cap, w_last, w_want, w_in_range, w_rd_en, w_err, w_accept;
  y86_ilen_decode u_dec (.i_icode(i_mem_rd_data[7:4]), .o_len(w_dec_len));
  assign w_accept   = r_state == S_IDLE && i_req_valid;
  assign w_addr     = {1'b0, r_pc} + AW1'(r_i);
  assign w_in_range = w_addr < AW1'(MEM_BYTES);
  assign w_k        = r_i - 4'd1;
  assign w_cap      = r_state == S_READ && r_i != 4'd0;
  assign w_len      = (w_k == 4'd0) ? w_dec_len : r_len;
  assign w_last     = w_cap && w_k == w_len - 4'd1;
  assign w_want     = r_i < 4'd2 || r_i < r_len;
  assign w_rd_en    = r_state == S_READ && w_want && w_in_range;
  assign w_end      = {1'b0, r_pc} + AW1'(w_len) - AW1'(1);
  assign w_err      = w_end >= AW1'(MEM_BYTES);
  assign o_req_ready     = r_state == S_IDLE;
  assign o_resp_valid    = r_state == S_DONE;
  assign o_mem_rd_en     = w_rd_en;
  assign o_mem_addr      = w_rd_en ? w_addr[ADDR_W-1:0] : '0;
  assign o_resp_instruct = r_buf;
  assign o_resp_len      = r_len;
  assign o_resp_err      = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = !i_req_valid ? S_IDLE : (i_req_pc >= ADDR_W'(MEM_BYTES)) ? S_ERR_IMM : S_READ;
      S_READ:    w_next = w_last ? S_DONE : S_READ;
      S_ERR_IMM: w_next = S_DONE;
      S_DONE:    w_next = i_resp_ready ? S_IDLE : S_DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc   <= '0;
      r_i    <= '0;
      r_len  <= '0;
      r_err  <= 1'b0;
      r_rd_q <= 1'b0;
      r_buf  <= '0;
    end else begin
      r_rd_q <= w_rd_en;
      if (w_accept) begin
        r_pc  <= i_req_pc;
        r_buf <= '0;
        r_i   <= '0;
      end else if (r_state == S_READ) begin
        r_i <= r_i + 4'd1;
        if (w_cap && r_rd_q) r_buf <= r_buf | ({i_mem_rd_data, {(INSTR_W-8){1'b0}}} >> {w_k, 3'b000});
        if (w_cap && w_k == 4'd0) r_len <= w_dec_len;
        if (w_last) r_err <= w_err;
      end else if (r_state == S_ERR_IMM) begin
        r_len <= 4'd1;
        r_err <= 1'b1;
      end
    end
endmodule
